// File: rtl/vga_pixel_sink_if.sv
// Pixel-plot port between a drawing FSM (master) and the framebuffer sink (slave).
interface vga_pixel_sink_if;
    logic [2:0] color;
    logic [8:0] x;
    logic [7:0] y;
    logic       plot;
    logic       busy;
    logic [7:0] oob_count;

    modport master (output color, x, y, plot, input busy, oob_count);
    modport slave  (input color, x, y, plot, output busy, oob_count);
endinterface

// File: rtl/vga_pixel_sink.sv
// Framebuffer sink: stores plotted pixels and scans them out as 640x480@60 VGA,
// replicating each stored pixel SCALE x SCALE.
module vga_pixel_sink #(
    parameter int         FB_W     = 160,
    parameter int         FB_H     = 120,
    parameter int         SCALE    = 4,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic             clk,
    input  logic             rst,
    vga_pixel_sink_if.slave  pix_if,
    output logic [9:0]       VGA_R,
    output logic [9:0]       VGA_G,
    output logic [9:0]       VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK,
    output logic             VGA_SYNC,
    output logic             VGA_CLK
);
    localparam int         FB_SIZE   = FB_W * FB_H;
    localparam int         SHIFT     = $clog2(SCALE);
    localparam logic [14:0] LAST_ADDR = 15'(FB_SIZE - 1);

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_SYNC_LO = 10'd656;
    localparam logic [9:0] H_SYNC_HI = 10'd751;
    localparam logic [9:0] H_LAST    = 10'd799;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_SYNC_LO = 10'd490;
    localparam logic [9:0] V_SYNC_HI = 10'd491;
    localparam logic [9:0] V_LAST    = 10'd524;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t      r_state;
    logic [14:0] r_clear_addr;
    logic        r_busy;
    logic [7:0]  r_oob_count;
    logic        r_pix_en;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_hs;
    logic        r_vs;
    logic        r_vis;
    logic [2:0]  r_pix;
    logic [2:0]  r_fb [FB_SIZE];

    logic        w_in_range;
    logic        w_visible;
    logic        w_show;
    logic        w_we;
    logic [14:0] w_wr_addr;
    logic [14:0] w_rd_addr;
    logic [14:0] w_fb_addr;
    logic [2:0]  w_fb_data;

    // Row start address; the default geometry uses y*160 = (y<<7)+(y<<5).
    function automatic logic [14:0] row_base(input logic [7:0] row);
        logic [14:0] r;
        r = {7'd0, row};
        if (FB_W == 160) return (r << 7) + (r << 5);
        return 15'(r * FB_W);
    endfunction

    assign w_in_range = (pix_if.x < 9'(FB_W)) && (pix_if.y < 8'(FB_H));
    assign w_wr_addr  = row_base(pix_if.y) + {6'd0, pix_if.x};
    assign w_rd_addr  = row_base(8'(r_v_cnt >> SHIFT)) + 15'(r_h_cnt >> SHIFT);
    assign w_visible  = (r_h_cnt < H_VISIBLE) && (r_v_cnt < V_VISIBLE);

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        w_we      = 1'b0;
        w_fb_addr = w_wr_addr;
        w_fb_data = pix_if.color;
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                w_we      = 1'b1;
                w_fb_addr = r_clear_addr;
                w_fb_data = BG_COLOR;
            end else if (pix_if.plot && w_in_range) begin
                w_we = 1'b1;
            end
        end
    end

    // NOTE: the framebuffer has no reset; the CLEAR state initialises it.
    // A same-cycle read of the written address returns the old contents.
    always_ff @(posedge clk) begin
        if (w_we) r_fb[w_fb_addr] <= w_fb_data;
        if (r_pix_en && w_visible) r_pix <= r_fb[w_rd_addr];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_CLEAR;
            r_clear_addr <= '0;
            r_busy       <= 1'b1;
            r_oob_count  <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clear_addr == LAST_ADDR) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clear_addr <= r_clear_addr + 15'd1;
                    end
                end
                ST_RUN: begin
                    if (pix_if.plot && !w_in_range && r_oob_count != 8'hFF)
                        r_oob_count <= r_oob_count + 8'd1;
                end
            endcase
        end
    end

    // Sync and visible flags are registered on the same tick as the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_en <= 1'b0;
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_vis    <= 1'b0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                r_hs  <= !((r_h_cnt >= H_SYNC_LO) && (r_h_cnt <= H_SYNC_HI));
                r_vs  <= !((r_v_cnt >= V_SYNC_LO) && (r_v_cnt <= V_SYNC_HI));
                r_vis <= w_visible;
                if (r_h_cnt == H_LAST) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

    assign w_show           = r_vis & ~r_busy;
    assign VGA_R            = {10{r_pix[2] & w_show}};
    assign VGA_G            = {10{r_pix[1] & w_show}};
    assign VGA_B            = {10{r_pix[0] & w_show}};
    assign VGA_HS           = r_hs;
    assign VGA_VS           = r_vs;
    assign VGA_BLANK        = r_vis;
    assign VGA_SYNC         = 1'b0;
    assign VGA_CLK          = r_pix_en;
    assign pix_if.busy      = r_busy;
    assign pix_if.oob_count = r_oob_count;
endmodule

// File: tb/tb_vga_pixel_sink.sv
// Randomised plot stimulus checked against a screen-level model of the sink.
module tb_vga_pixel_sink;
    localparam int FB_W         = 160;
    localparam int FB_H         = 120;
    localparam int FB_SIZE      = FB_W * FB_H;
    localparam int CLEAR_CYCLES = FB_SIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    vga_pixel_sink_if pif ();
    logic [9:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank, vga_sync, vga_clk;

    vga_pixel_sink dut (
        .clk      (clk),
        .rst      (rst),
        .pix_if   (pif),
        .VGA_R    (vga_r),
        .VGA_G    (vga_g),
        .VGA_B    (vga_b),
        .VGA_HS   (vga_hs),
        .VGA_VS   (vga_vs),
        .VGA_BLANK(vga_blank),
        .VGA_SYNC (vga_sync),
        .VGA_CLK  (vga_clk)
    );

    int checks = 0;
    int errors = 0;
    int n;          // clk edges since reset was released
    int line_bad;
    int oob_model;
    logic [2:0] fb_cur  [FB_SIZE];
    logic [2:0] fb_prev [FB_SIZE];
    int         fb_wr_edge [FB_SIZE];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] rgb_of(input logic [2:0] c);
        return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    endfunction

    // A read on the same edge as a write (or earlier) sees the previous value.
    function automatic logic [2:0] model_read(input int addr, input int read_edge);
        return (fb_wr_edge[addr] >= read_edge) ? fb_prev[addr] : fb_cur[addr];
    endfunction

    task automatic plot(input int px, input int py, input logic [2:0] c);
        int a;
        pif.x     = 9'(px);
        pif.y     = 8'(py);
        pif.color = c;
        pif.plot  = 1'b1;
        if (px < FB_W && py < FB_H) begin
            a             = py * FB_W + px;
            fb_prev[a]    = fb_cur[a];
            fb_cur[a]     = c;
            fb_wr_edge[a] = n + 1;
        end else if (oob_model < 255) begin
            oob_model++;
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    // Pins after edge n show raster position p = n/2-1 (one pixel tick behind the counters).
    always @(negedge clk) begin : scan_monitor
        int p, h, v;
        logic vis, hs_e, vs_e;
        logic [2:0] px;
        logic [34:0] got_v, exp_v;
        if (rst) begin
            line_bad = 0;
        end else if (n >= 2) begin
            p    = n / 2 - 1;
            h    = p % 800;
            v    = (p / 800) % 525;
            vis  = (h < 640) && (v < 480);
            hs_e = !(h >= 656 && h <= 751);
            vs_e = !(v >= 490 && v <= 491);
            px   = (vis && n >= CLEAR_CYCLES) ? model_read((v / 4) * FB_W + h / 4, 2 * (p + 1)) : 3'b000;
            got_v = {vga_hs, vga_vs, vga_blank, vga_sync, vga_clk, vga_r, vga_g, vga_b};
            exp_v = {hs_e, vs_e, vis, 1'b0, 1'(n % 2), rgb_of(px)};
            if (got_v !== exp_v) line_bad++;
            if (h == 799 && (n % 2) == 1) begin
                check($sformatf("scan_line%0d", v), line_bad, 0);
                line_bad = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard, lo, hi, bl, a;
        logic [2:0] old_c, new_c;

        pif.plot = 1'b0; pif.color = '0; pif.x = '0; pif.y = '0;
        oob_model = 0;
        for (int i = 0; i < FB_SIZE; i++) begin
            fb_cur[i] = 3'b000; fb_prev[i] = 3'b000; fb_wr_edge[i] = 0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  pif.busy, 1);
        check("rst_oob",   pif.oob_count, 0);
        check("rst_hs",    vga_hs, 1);
        check("rst_vs",    vga_vs, 1);
        check("rst_blank", vga_blank, 0);
        check("rst_rgb",   {vga_r, vga_g, vga_b}, 0);
        rst = 1'b0;

        // Reset mid-clear, mid-frame, while HS is low (line 2, h=700).
        while (n < 4602) @(negedge clk);
        check("pre_rst_hs", vga_hs, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_hs",    vga_hs, 1);
        check("mid_rst_vs",    vga_vs, 1);
        check("mid_rst_blank", vga_blank, 0);
        check("mid_rst_busy",  pif.busy, 1);
        rst = 1'b0;

        // Plots late in the clear target rows already cleared; they must be dropped.
        while (n < 18000) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            pif.x     = (i % 4 == 0) ? 9'($urandom_range(160, 511)) : 9'($urandom_range(0, 159));
            pif.y     = 8'($urandom_range(5, 8));
            pif.color = 3'b111;
            pif.plot  = 1'b1;
            @(negedge clk);
        end
        pif.plot = 1'b0;
        check("clear_oob", pif.oob_count, 0);

        guard = 0;
        while (pif.busy && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        check("clear_len", n, CLEAR_CYCLES);
        check("run_busy",  pif.busy, 0);

        plot(0, 0, 3'b100);
        plot(159, 119, 3'b011);
        plot(160, 5, 3'b010);
        pif.plot = 1'b0;
        check("oob_one", pif.oob_count, 1);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       plot($urandom_range(160, 511), $urandom_range(0, 255), 3'($urandom_range(0, 7)));
                1:       plot($urandom_range(0, 159), $urandom_range(120, 255), 3'($urandom_range(0, 7)));
                default: plot($urandom_range(0, 159), $urandom_range(5, 119), 3'($urandom_range(0, 7)));
            endcase
        end
        pif.plot = 1'b0;
        check("oob_rand", pif.oob_count, oob_model);

        plot(0, 6, 3'b100);
        plot(159, 6, 3'b011);
        plot(1, 6, 3'b000);
        for (int i = 0; i < 300; i++)
            plot($urandom_range(160, 511), $urandom_range(0, 255), 3'($urandom_range(0, 7)));
        pif.plot = 1'b0;
        check("oob_sat", pif.oob_count, 255);

        guard = 0;
        while (vga_hs && guard < 2000) begin @(negedge clk); guard++; end
        lo = 0;
        while (!vga_hs && lo < 2000) begin @(negedge clk); lo++; end
        hi = 0;
        while (vga_hs && hi < 2000) begin @(negedge clk); hi++; end
        check("hs_low",    lo, 192);
        check("hs_period", lo + hi, 1600);

        guard = 0;
        while (!vga_blank && guard < 2000) begin @(negedge clk); guard++; end
        bl = 0;
        while (vga_blank && bl < 2000) begin @(negedge clk); bl++; end
        check("blank_high", bl, 1280);

        // Screen line 24 shows framebuffer row 6.
        while (n < 2 * (24 * 800 + 0 + 1)) @(negedge clk);
        check("px_0_24",   {vga_r, vga_g, vga_b}, {10'h3FF, 10'h000, 10'h000});
        while (n < 2 * (24 * 800 + 4 + 1)) @(negedge clk);
        check("px_4_24",   {vga_r, vga_g, vga_b}, 30'h0);
        while (n < 2 * (24 * 800 + 636 + 1)) @(negedge clk);
        check("px_636_24", {vga_r, vga_g, vga_b}, {10'h000, 10'h3FF, 10'h3FF});

        // Write (20,8) on the very edge that scans screen (80,32).
        while (n < 2 * (32 * 800 + 80 + 1) - 1) @(negedge clk);
        a     = 8 * FB_W + 20;
        old_c = fb_cur[a];
        new_c = ~old_c;
        plot(20, 8, new_c);
        pif.plot = 1'b0;
        check("collide_old", {vga_r, vga_g, vga_b}, rgb_of(old_c));
        @(negedge clk);
        @(negedge clk);
        check("collide_new", {vga_r, vga_g, vga_b}, rgb_of(new_c));

        while (n < 2 * 34 * 800) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
